alarm_timer_sched: RTL and testbench
====================================

Name: alarm_timer_sched

Overview:
Central timing scheduler for the alarm system. It owns the four programmable time parameters (arm delay, driver delay, passenger delay, alarm-on), the clock-to-second prescaler and the single shared countdown. The alarm FSM requests a countdown by parameter index and receives busy, remaining and a one-cycle expiry pulse. A separate programming port rewrites parameters at run time without disturbing a countdown already in progress.

Parameters:
CLK_PER_TICK, 50000000, clock cycles per 1-second tick (benches use 4)
PW, 4, width of each time parameter and of the countdown
DEF_ARM, 6, reset value of parameter 0 (arm delay)
DEF_DRIVER, 8, reset value of parameter 1 (driver delay)
DEF_PASSENGER, 14, reset value of parameter 2 (passenger delay)
DEF_ALARM_ON, 10, reset value of parameter 3 (alarm-on time)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  request a countdown; sampled every cycle
sel  in  2  parameter index for start
abort  in  1  cancel the running countdown
prog  in  1  parameter write strobe
prog_sel  in  2  index to write
prog_val  in  PW  value to write
prog_ack  out  1  one-cycle pulse: write accepted
prog_err  out  1  one-cycle pulse: write rejected
busy  out  1  countdown in progress
remaining  out  PW  seconds left in the current/last countdown
expired  out  1  one-cycle pulse: countdown reached 0
param_rd  out  PW  current value of parameter sel (combinational read)

Behaviour:
- Reset (sync, checked at posedge clock): state=IDLE; busy=0, expired=0, prog_ack=0, prog_err=0, remaining=0, prescaler=0; params := DEF_* values. Reset mid-count drops the count with no expired pulse.
- States: IDLE, COUNT, DONE. All outputs are registered except param_rd.
- IDLE/DONE + start at edge k: remaining <= param[sel] (pre-write value); prescaler <= 0; busy <= 1; state <= COUNT. If param[sel]==0, go straight to DONE: busy stays 0 and expired=1 after edge k.
- COUNT: prescaler increments each cycle. A tick occurs when prescaler==CLK_PER_TICK-1; the prescaler then wraps to 0 and remaining decrements.
  - Value N started at edge k: decrements at edges k+C, k+2C, ... (C=CLK_PER_TICK).
  - At the edge where remaining goes 1->0 (k+N*C): state <= DONE, busy <= 0, expired <= 1.
- DONE: expired held for exactly one cycle. Next edge: expired <= 0 and state <= IDLE, unless start is accepted in that same cycle (handled as from IDLE).
- COUNT + start (retrigger): reload remaining <= param[sel] and clear prescaler; no expired pulse.
- COUNT + abort: state <= IDLE, busy <= 0; remaining frozen at its current value; no expired pulse.
- abort and start in the same cycle: abort wins and start is dropped. abort in IDLE/DONE is ignored (an expired pulse already scheduled still occurs).
- prog at edge j:
  - prog_val!=0: param[prog_sel] <= prog_val and prog_ack=1 for cycle j+1.
  - prog_val==0: rejected, param unchanged, prog_err=1 for cycle j+1.
  - Back-to-back prog pulses give back-to-back acks.
- prog never alters remaining or the prescaler of a running count. prog and start in the same cycle on the same index: start loads the old value.
- param_rd = param[sel] combinationally; it reflects a write from the cycle after the writing edge.
- Width: remaining never underflows. Decrement happens only when remaining>=1; max value 2^PW-1.

Test Plan:
- Defaults: C=4, reset, start sel=1 at edge k -> busy=1, remaining=8 after k; decrements every 4 cycles; at edge k+32 remaining=0, busy=0, expired=1 for exactly one cycle, then IDLE.
- Zero/short: program param 0 := 1 (prog_ack pulse), start sel=0 -> expired after 4 cycles. Program value 0 -> prog_err pulse, param_rd still 1.
- Retrigger/abort: start sel=3 (10), after 9 cycles start sel=0 -> remaining=6, prescaler restarted, no expired. Then abort+start same cycle -> busy=0, remaining frozen, no expired ever.
- Prog during count: start sel=2 (14), prog sel=2 := 3 mid-count -> count still expires at 14*4 cycles; next start sel=2 loads 3.
- Same-cycle prog+start on index 1 with prog_val=5 -> remaining=8 (old value), param_rd=5 next cycle.
- Reset mid-count at remaining=4 -> next cycle busy=0, remaining=0, no expired; all params back to 6/8/14/10.

Source files
------------

// File: rtl/alarm_timer_sched_if.sv
// alarm_timer_sched_if: request/programming bus between the alarm FSM and the timing scheduler
interface alarm_timer_sched_if #(parameter int PW = 4);
   logic          start;
   logic [1:0]    sel;
   logic          abort;
   logic          prog;
   logic [1:0]    prog_sel;
   logic [PW-1:0] prog_val;
   logic          prog_ack;
   logic          prog_err;
   logic          busy;
   logic [PW-1:0] remaining;
   logic          expired;
   logic [PW-1:0] param_rd;
   modport master (
      output start, sel, abort, prog, prog_sel, prog_val,
      input  prog_ack, prog_err, busy, remaining, expired, param_rd
   );
   modport slave (
      input  start, sel, abort, prog, prog_sel, prog_val,
      output prog_ack, prog_err, busy, remaining, expired, param_rd
   );
endinterface

// File: rtl/alarm_timer_sched.sv
// alarm_timer_sched: parameter store, 1 s prescaler and shared countdown for the alarm FSM
module alarm_timer_sched #(
   parameter int CLK_PER_TICK  = 50000000,
   parameter int PW            = 4,
   parameter int DEF_ARM       = 6,
   parameter int DEF_DRIVER    = 8,
   parameter int DEF_PASSENGER = 14,
   parameter int DEF_ALARM_ON  = 10
) (
   input logic              clock_i,
   input logic              reset_i,
   alarm_timer_sched_if.slave bus
);
   localparam int CW = CLK_PER_TICK > 1 ? $clog2(CLK_PER_TICK) : 1;
   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] presc_q, presc_d;
   logic [PW-1:0] remaining_q, remaining_d;
   logic          busy_q, busy_d, expired_q, expired_d, ack_q, err_q;
   logic [PW-1:0] param_q [4];
   logic [PW-1:0] load;
   logic          tick;
   assign load          = param_q[bus.sel];
   assign tick          = presc_q == CW'(CLK_PER_TICK - 1);
   assign bus.param_rd  = load;
   assign bus.busy      = busy_q;
   assign bus.remaining = remaining_q;
   assign bus.expired   = expired_q;
   assign bus.prog_ack  = ack_q;
   assign bus.prog_err  = err_q;
   // parameter writes: zero values are rejected so a countdown can never be programmed empty
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         param_q[0] <= PW'(DEF_ARM);
         param_q[1] <= PW'(DEF_DRIVER);
         param_q[2] <= PW'(DEF_PASSENGER);
         param_q[3] <= PW'(DEF_ALARM_ON);
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         if (bus.prog && bus.prog_val != '0) param_q[bus.prog_sel] <= bus.prog_val;
         ack_q <= bus.prog && bus.prog_val != '0;
         err_q <= bus.prog && bus.prog_val == '0;
      end
   end
   // countdown state register
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         presc_q     <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         expired_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         expired_q   <= expired_d;
      end
   end
   // next state: start loads the pre-write parameter; abort only acts on a running count
   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      remaining_d = remaining_q;
      busy_d      = busy_q;
      expired_d   = 1'b0;
      if (state_q == COUNT && bus.abort) begin
         state_d = IDLE;
         busy_d  = 1'b0;
      end else if (bus.start) begin
         remaining_d = load;
         presc_d     = '0;
         state_d     = load == '0 ? DONE : COUNT;
         busy_d      = load != '0;
         expired_d   = load == '0;
      end else if (state_q == COUNT) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (tick && remaining_q != '0) begin
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == PW'(1)) begin
               state_d   = DONE;
               busy_d    = 1'b0;
               expired_d = 1'b1;
            end
         end
      end else begin
         state_d = IDLE;
         busy_d  = 1'b0;
      end
   end
endmodule

// File: tb/tb_alarm_timer_sched.sv
// tb_alarm_timer_sched: directed scenario checks of the alarm timing scheduler with a 4-cycle tick
module tb_alarm_timer_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   failed = 0;
   alarm_timer_sched_if #(.PW(4)) bus ();
   alarm_timer_sched #(.CLK_PER_TICK(4), .PW(4)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );
   always #5 clk = ~clk;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      logic [3:0] defs [4];
      defs = '{4'd6, 4'd8, 4'd14, 4'd10};
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %0d exp 0", bus.busy); end
      tests++; if (bus.remaining !== 4'd0) begin failed++; $display("FAIL reset_remaining got %0d exp 0", bus.remaining); end
      tests++; if (bus.expired !== 1'b0) begin failed++; $display("FAIL reset_expired got %0d exp 0", bus.expired); end
      tests++; if ({bus.prog_ack, bus.prog_err} !== 2'b00) begin failed++; $display("FAIL reset_prog got %b exp 00", {bus.prog_ack, bus.prog_err}); end
      for (int s = 0; s < 4; s++) begin
         bus.sel = 2'(s);
         #1;
         tests++; if (bus.param_rd !== defs[s]) begin failed++; $display("FAIL reset_param%0d got %0d exp %0d", s, bus.param_rd, defs[s]); end
      end
   endtask
   task automatic test_defaults();
      int pulses = 0;
      bus.sel = 2'd1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      tests++; if (bus.busy !== 1'b1 || bus.remaining !== 4'd8) begin failed++; $display("FAIL def_start got busy=%0d rem=%0d exp busy=1 rem=8", bus.busy, bus.remaining); end
      for (int i = 1; i <= 32; i++) begin
         step();
         pulses += int'(bus.expired);
         tests++; if (bus.remaining !== 4'(8 - i / 4)) begin failed++; $display("FAIL def_rem@%0d got %0d exp %0d", i, bus.remaining, 8 - i / 4); end
         tests++; if (bus.busy !== (i < 32)) begin failed++; $display("FAIL def_busy@%0d got %0d exp %0d", i, bus.busy, i < 32); end
      end
      tests++; if (bus.expired !== 1'b1 || pulses != 1) begin failed++; $display("FAIL def_expired got %0d pulses=%0d exp 1 pulses=1", bus.expired, pulses); end
      step();
      tests++; if (bus.expired !== 1'b0 || bus.busy !== 1'b0) begin failed++; $display("FAIL def_after got exp=%0d busy=%0d exp 0 0", bus.expired, bus.busy); end
   endtask
   task automatic test_retrigger_abort();
      bus.sel = 2'd3; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      tests++; if (bus.remaining !== 4'd10) begin failed++; $display("FAIL rt_load got %0d exp 10", bus.remaining); end
      repeat (9) step();
      tests++; if (bus.remaining !== 4'd8) begin failed++; $display("FAIL rt_before got %0d exp 8", bus.remaining); end
      bus.sel = 2'd0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      tests++; if (bus.remaining !== 4'd6 || bus.busy !== 1'b1 || bus.expired !== 1'b0) begin failed++; $display("FAIL rt_reload got rem=%0d busy=%0d exp=%0d exp 6 1 0", bus.remaining, bus.busy, bus.expired); end
      repeat (3) step();
      tests++; if (bus.remaining !== 4'd6) begin failed++; $display("FAIL rt_presc_hold got %0d exp 6", bus.remaining); end
      step();
      tests++; if (bus.remaining !== 4'd5) begin failed++; $display("FAIL rt_presc_tick got %0d exp 5", bus.remaining); end
      bus.abort = 1'b1; bus.start = 1'b1; bus.sel = 2'd2;
      step();
      bus.abort = 1'b0; bus.start = 1'b0;
      tests++; if (bus.busy !== 1'b0 || bus.remaining !== 4'd5) begin failed++; $display("FAIL ab_stop got busy=%0d rem=%0d exp 0 5", bus.busy, bus.remaining); end
      for (int i = 0; i < 30; i++) begin
         step();
         tests++; if (bus.expired !== 1'b0 || bus.remaining !== 4'd5) begin failed++; $display("FAIL ab_frozen@%0d got exp=%0d rem=%0d exp 0 5", i, bus.expired, bus.remaining); end
      end
   endtask
   task automatic test_short();
      bus.prog = 1'b1; bus.prog_sel = 2'd0; bus.prog_val = 4'd1;
      step();
      bus.prog = 1'b0;
      tests++; if ({bus.prog_ack, bus.prog_err} !== 2'b10) begin failed++; $display("FAIL sh_ack got %b exp 10", {bus.prog_ack, bus.prog_err}); end
      step();
      tests++; if (bus.prog_ack !== 1'b0) begin failed++; $display("FAIL sh_ack_pulse got %0d exp 0", bus.prog_ack); end
      bus.sel = 2'd0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      tests++; if (bus.busy !== 1'b1 || bus.remaining !== 4'd1) begin failed++; $display("FAIL sh_load got busy=%0d rem=%0d exp 1 1", bus.busy, bus.remaining); end
      repeat (3) step();
      tests++; if (bus.expired !== 1'b0) begin failed++; $display("FAIL sh_early got %0d exp 0", bus.expired); end
      step();
      tests++; if (bus.expired !== 1'b1 || bus.remaining !== 4'd0 || bus.busy !== 1'b0) begin failed++; $display("FAIL sh_expire got exp=%0d rem=%0d busy=%0d exp 1 0 0", bus.expired, bus.remaining, bus.busy); end
      bus.prog = 1'b1; bus.prog_val = 4'd0;
      step();
      bus.prog = 1'b0;
      tests++; if ({bus.prog_ack, bus.prog_err} !== 2'b01) begin failed++; $display("FAIL sh_err got %b exp 01", {bus.prog_ack, bus.prog_err}); end
      tests++; if (bus.param_rd !== 4'd1) begin failed++; $display("FAIL sh_keep got %0d exp 1", bus.param_rd); end
      step();
      tests++; if (bus.prog_err !== 1'b0) begin failed++; $display("FAIL sh_err_pulse got %0d exp 0", bus.prog_err); end
   endtask
   task automatic test_prog_during_count();
      bus.sel = 2'd2; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      tests++; if (bus.remaining !== 4'd14) begin failed++; $display("FAIL pc_load got %0d exp 14", bus.remaining); end
      for (int i = 1; i <= 56; i++) begin
         bus.prog = i == 3; bus.prog_sel = 2'd2; bus.prog_val = 4'd3;
         step();
         if (i == 3) begin
            tests++; if (bus.prog_ack !== 1'b1 || bus.remaining !== 4'd14) begin failed++; $display("FAIL pc_ack got ack=%0d rem=%0d exp 1 14", bus.prog_ack, bus.remaining); end
         end
         tests++; if (bus.expired !== (i == 56)) begin failed++; $display("FAIL pc_expired@%0d got %0d exp %0d", i, bus.expired, i == 56); end
      end
      bus.prog = 1'b0;
      step();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      tests++; if (bus.remaining !== 4'd3) begin failed++; $display("FAIL pc_newval got %0d exp 3", bus.remaining); end
      bus.abort = 1'b1;
      step();
      bus.abort = 1'b0;
   endtask
   task automatic test_same_cycle_and_reset();
      logic [3:0] defs [4];
      defs = '{4'd6, 4'd8, 4'd14, 4'd10};
      bus.sel = 2'd1; bus.start = 1'b1;
      bus.prog = 1'b1; bus.prog_sel = 2'd1; bus.prog_val = 4'd5;
      step();
      bus.start = 1'b0; bus.prog = 1'b0;
      tests++; if (bus.remaining !== 4'd8 || bus.busy !== 1'b1) begin failed++; $display("FAIL sc_old got rem=%0d busy=%0d exp 8 1", bus.remaining, bus.busy); end
      tests++; if (bus.param_rd !== 4'd5 || bus.prog_ack !== 1'b1) begin failed++; $display("FAIL sc_new got rd=%0d ack=%0d exp 5 1", bus.param_rd, bus.prog_ack); end
      repeat (16) step();
      tests++; if (bus.remaining !== 4'd4) begin failed++; $display("FAIL rs_before got %0d exp 4", bus.remaining); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests++; if (bus.busy !== 1'b0 || bus.remaining !== 4'd0 || bus.expired !== 1'b0) begin failed++; $display("FAIL rs_mid got busy=%0d rem=%0d exp=%0d exp 0 0 0", bus.busy, bus.remaining, bus.expired); end
      for (int s = 0; s < 4; s++) begin
         bus.sel = 2'(s);
         #1;
         tests++; if (bus.param_rd !== defs[s]) begin failed++; $display("FAIL rs_param%0d got %0d exp %0d", s, bus.param_rd, defs[s]); end
      end
      for (int i = 0; i < 40; i++) begin
         step();
         tests++; if (bus.expired !== 1'b0 || bus.busy !== 1'b0) begin failed++; $display("FAIL rs_quiet@%0d got exp=%0d busy=%0d exp 0 0", i, bus.expired, bus.busy); end
      end
   endtask
   initial begin
      bus.start = 1'b0; bus.sel = 2'd0; bus.abort = 1'b0;
      bus.prog = 1'b0; bus.prog_sel = 2'd0; bus.prog_val = 4'd0;
      step();
      test_reset();
      test_defaults();
      test_retrigger_abort();
      test_short();
      test_prog_during_count();
      test_same_cycle_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
